// File: rtl/inject_arbiter.sv
`default_nettype none
//----------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : inject_arbiter                                             |
// | Description : Stream-locking round-robin arbiter that merges N_REQ        |
// |               flit injectors onto one NoC injection port. A grant is     |
// |               held for as long as the owner keeps its tx_i asserted,     |
// |               so a multi-flit transfer is never interleaved with         |
// |               another requester's flits.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//
// Ports
//   clk_i       in   1                 clock, rising edge
//   rst_ni      in   1                 asynchronous active-low reset
//   tx_i        in   N_REQ             per-requester flit valid / stream hold
//   data_i      in   N_REQ*FLIT_SIZE   per-requester flit, r at [r*FLIT_SIZE +: FLIT_SIZE]
//   credit_o    out  N_REQ             per-requester credit return
//   eoa_i       in   N_REQ             per-requester end-of-applications
//   tx_o        out  1                 flit valid toward the NoC
//   credit_i    in   1                 credit from the NoC
//   data_o      out  FLIT_SIZE         granted flit
//   eoa_o       out  1                 all requesters finished (registered)
//   busy_o      out  1                 a grant is held
//   owner_o     out  clog2(N_REQ)      current owner (BUSY) / last owner (IDLE)
//   flit_cnt_o  out  32                flits transferred under the current grant
//----------------------------------------------------------------------------
module inject_arbiter #(
    parameter int FLIT_SIZE = 32,
    parameter int N_REQ     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_REQ-1:0]             tx_i,
    input  logic [N_REQ*FLIT_SIZE-1:0]   data_i,
    output logic [N_REQ-1:0]             credit_o,
    input  logic [N_REQ-1:0]             eoa_i,
    output logic                         tx_o,
    input  logic                         credit_i,
    output logic [FLIT_SIZE-1:0]         data_o,
    output logic                         eoa_o,
    output logic                         busy_o,
    output logic [$clog2(N_REQ)-1:0]     owner_o,
    output logic [31:0]                  flit_cnt_o
);

    localparam int OW = $clog2(N_REQ);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_owner_q, last_owner_d;
    logic [31:0]     flit_cnt_q, flit_cnt_d;
    logic            eoa_q, eoa_d;

    logic [OW-1:0]   rr_winner;
    logic            owner_tx;
    logic [FLIT_SIZE-1:0] owner_data;

    // Round-robin pick: the first requesting index found when walking up
    // from last+1 with wrap-around. Only consulted when some tx_i is set,
    // so the fallback value is never used for a grant.
    function automatic logic [OW-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [OW-1:0]    last
    );
        logic [OW-1:0] pick;
        logic [OW-1:0] cand;
        logic          found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = OW'((int'(last) + i) % N_REQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign rr_winner = rr_pick(tx_i, last_owner_q);

    // Owner-side selection of the stream-hold bit and the flit.
    always_comb begin
        owner_tx   = 1'b0;
        owner_data = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (owner_q == OW'(r)) begin
                owner_tx   = tx_i[r];
                owner_data = data_i[r*FLIT_SIZE +: FLIT_SIZE];
            end
        end
    end

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            // Starting from the top index makes requester 0 win the first
            // arbitration after reset.
            last_owner_q <= OW'(N_REQ - 1);
            flit_cnt_q   <= '0;
            eoa_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            flit_cnt_q   <= flit_cnt_d;
            eoa_q        <= eoa_d;
        end
    end

    //------------------------------------------------------------------
    // Next-state and output logic
    //------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        flit_cnt_d   = flit_cnt_q;
        tx_o         = 1'b0;
        credit_o     = '0;
        data_o       = '0;

        case (state_q)
            IDLE: begin
                // Arbitration cycle: nothing is forwarded here, which
                // costs one bubble per grant but keeps the mux registered.
                if (|tx_i) begin
                    owner_d    = rr_winner;
                    flit_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                tx_o              = owner_tx;
                data_o            = owner_data;
                credit_o[owner_q] = credit_i;
                if (owner_tx) begin
                    // Stream lock: other requesters are ignored while the
                    // owner holds tx. A missing credit simply stalls.
                    if (credit_i) begin
                        flit_cnt_d = flit_cnt_q + 32'd1;
                    end
                end else begin
                    // Release without re-arbitrating on the same edge.
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // End-of-applications is only declared from a quiet IDLE state.
    assign eoa_d = (state_q == IDLE) && (&eoa_i) && !(|tx_i);

    assign eoa_o      = eoa_q;
    assign busy_o     = (state_q == BUSY);
    assign owner_o    = (state_q == BUSY) ? owner_q : last_owner_q;
    assign flit_cnt_o = flit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inject_arbiter.sv
`default_nettype none
//----------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_inject_arbiter                                          |
// | Description : Directed self-checking bench for inject_arbiter with a     |
// |               2-requester and a 4-requester instance.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//----------------------------------------------------------------------------
module tb_inject_arbiter;

    logic clk;
    logic rst_n;

    // 2-requester instance, 32-bit flits
    logic [1:0]  tx2, credit_o2, eoa2;
    logic [63:0] data2;
    logic        tx_o2, credit2, eoa_o2, busy2;
    logic [31:0] dout2;
    logic [0:0]  owner2;
    logic [31:0] cnt2;

    // 4-requester instance, 8-bit flits
    logic [3:0]  tx4, credit_o4, eoa4;
    logic [31:0] data4;
    logic        tx_o4, credit4, eoa_o4, busy4;
    logic [7:0]  dout4;
    logic [1:0]  owner4;
    logic [31:0] cnt4;

    int checks = 0;
    int errors = 0;
    int pulses;

    inject_arbiter #(.FLIT_SIZE(32), .N_REQ(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .tx_i(tx2), .data_i(data2),
        .credit_o(credit_o2), .eoa_i(eoa2), .tx_o(tx_o2), .credit_i(credit2),
        .data_o(dout2), .eoa_o(eoa_o2), .busy_o(busy2), .owner_o(owner2),
        .flit_cnt_o(cnt2)
    );

    inject_arbiter #(.FLIT_SIZE(8), .N_REQ(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .tx_i(tx4), .data_i(data4),
        .credit_o(credit_o4), .eoa_i(eoa4), .tx_o(tx_o4), .credit_i(credit4),
        .data_o(dout4), .eoa_o(eoa_o4), .busy_o(busy4), .owner_o(owner4),
        .flit_cnt_o(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        tx2     = '0; eoa2 = '0; credit2 = 1'b0; data2 = {32'hBBBB0001, 32'hAAAA0000};
        tx4     = '0; eoa4 = '0; credit4 = 1'b0; data4 = {8'h33, 8'h22, 8'h11, 8'h00};

        // Reset values
        #12;
        chk("rst_busy",   busy2, 1'b0);
        chk("rst_tx",     tx_o2, 1'b0);
        chk("rst_credit", credit_o2, 2'b00);
        chk("rst_data",   dout2, 32'h0);
        chk("rst_owner",  owner2, 1'b1);
        chk("rst_cnt",    cnt2, 32'd0);
        chk("rst_eoa",    eoa_o2, 1'b0);
        chk("rst_owner4", owner4, 2'd3);
        rst_n = 1'b1;

        // Both request: requester 0 wins first
        tx2 = 2'b11;
        tick();
        chk("grant0_owner", owner2, 1'b0);
        chk("grant0_busy",  busy2, 1'b1);
        chk("grant0_tx",    tx_o2, 1'b1);
        chk("grant0_nocr",  credit_o2, 2'b00);
        chk("grant0_data",  dout2, 32'hAAAA0000);
        chk("grant0_cnt",   cnt2, 32'd0);

        // Stream 10 flits from requester 0
        credit2 = 1'b1;
        pulses  = 0;
        for (int k = 0; k < 10; k++) begin
            data2[31:0] = 32'hC0DE0000 + k;
            #1;
            chk("stream_data", dout2, 32'hC0DE0000 + k);
            chk("stream_cr1",  credit_o2[1], 1'b0);
            if (credit_o2[0] && tx_o2) pulses++;
            tick();
        end
        chk("stream_pulses", pulses, 10);
        chk("stream_cnt",    cnt2, 32'd10);

        // Credit stall for 5 cycles
        credit2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_tx",    tx_o2, 1'b1);
            chk("stall_cnt",   cnt2, 32'd10);
            chk("stall_owner", owner2, 1'b0);
            chk("stall_cr",    credit_o2, 2'b00);
        end
        credit2 = 1'b1;
        tick();
        chk("resume_cnt", cnt2, 32'd11);

        // Owner drops: requester 1 still gets no credit, then one IDLE cycle
        tx2 = 2'b10;
        #1;
        chk("drop_cr1", credit_o2[1], 1'b0);
        chk("drop_tx",  tx_o2, 1'b0);
        tick();
        chk("idle_busy",  busy2, 1'b0);
        chk("idle_owner", owner2, 1'b0);
        chk("idle_cr",    credit_o2, 2'b00);
        chk("idle_data",  dout2, 32'h0);
        chk("idle_cnt",   cnt2, 32'd11);
        tick();
        chk("grant1_owner", owner2, 1'b1);
        chk("grant1_busy",  busy2, 1'b1);
        chk("grant1_cnt",   cnt2, 32'd0);
        chk("grant1_data",  dout2, 32'hBBBB0001);
        chk("grant1_cr",    credit_o2, 2'b10);

        // Reset mid-stream after 3 flits
        tick(); tick(); tick();
        chk("pre_rst_cnt", cnt2, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy2, 1'b0);
        chk("mid_rst_tx",   tx_o2, 1'b0);
        chk("mid_rst_cnt",  cnt2, 32'd0);
        chk("mid_rst_cr",   credit_o2, 2'b00);
        chk("mid_rst_data", dout2, 32'h0);
        rst_n = 1'b1;
        tx2   = 2'b11;
        tick();
        chk("post_rst_owner", owner2, 1'b0);
        chk("post_rst_busy",  busy2, 1'b1);

        // End of applications
        tx2  = 2'b00;
        eoa2 = 2'b11;
        tick();
        chk("eoa_busy_edge", eoa_o2, 1'b0);
        chk("eoa_to_idle",   busy2, 1'b0);
        tick();
        chk("eoa_set", eoa_o2, 1'b1);
        eoa2 = 2'b01;
        tick();
        chk("eoa_partial", eoa_o2, 1'b0);
        eoa2 = 2'b11;
        tick();
        chk("eoa_reset", eoa_o2, 1'b1);
        tx2 = 2'b01;
        #1;
        chk("eoa_hold", eoa_o2, 1'b1);
        tick();
        chk("eoa_clear",  eoa_o2, 1'b0);
        chk("eoa_grant",  owner2, 1'b0);

        // 4-requester round robin: make last_owner = 2
        credit4 = 1'b1;
        tx4 = 4'b0100;
        tick();
        chk("rr4_first", owner4, 2'd2);
        tx4 = 4'b0000;
        tick();
        chk("rr4_idle_owner", owner4, 2'd2);
        chk("rr4_idle_busy",  busy4, 1'b0);
        tx4 = 4'b1011;
        tick();
        chk("rr4_win3",  owner4, 2'd3);
        chk("rr4_data3", dout4, 8'h33);
        chk("rr4_cr3",   credit_o4, 4'b1000);
        tx4 = 4'b0011;
        tick();
        chk("rr4_rel_busy", busy4, 1'b0);
        chk("rr4_rel_own",  owner4, 2'd3);
        tick();
        chk("rr4_win0",  owner4, 2'd0);
        chk("rr4_data0", dout4, 8'h00);
        chk("rr4_cr0",   credit_o4, 4'b0001);
        chk("rr4_cnt",   cnt4, 32'd0);
        tick();
        chk("rr4_cnt1",  cnt4, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
